ysyx_25020047_lsu_sram: RTL and testbench

// - Memory slave directly downstream of the LSU: turns the LSU's load/store requests into

---
 rtl/ysyx_25020047_lsu_sram.sv | 99 +++++++++
 tb/tb_ysyx_25020047_lsu_sram.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_sram.sv
// ysyx_25020047_lsu_sram: one-outstanding LSU memory slave with fixed LATENCY, backed by a word-array pmem model.
// Defining SRAM_RAND_DELAY_EN adds up to 3 cycles of LFSR-driven extra latency per request.
module ysyx_25020047_lsu_sram #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_wen
);
  localparam int AW = 10;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, lat;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        wen_q, wen_d, access;
  logic [31:0] mem [2**AW];
  logic        unused_addr;
  function automatic logic [31:0] pmem_read(input logic [31:0] a);
    pmem_read = mem[a[AW+1:2]];
  endfunction
  function automatic logic [31:0] pmem_write(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] m);
    pmem_write = {m[3] ? d[31:24] : old[31:24], m[2] ? d[23:16] : old[23:16],
                  m[1] ? d[15:8]  : old[15:8],  m[0] ? d[7:0]   : old[7:0]};
  endfunction
`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    lat    = 4'(LATENCY) + {2'b00, lfsr_q[1:0]};
  end
  always_ff @(posedge clk) lfsr_q <= !rst_n ? 4'b1001 : lfsr_d;
`else
  always_comb lat = 4'(LATENCY);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    access  = state_q == WAIT && cnt_q == 4'd0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        wmask_d = req_wmask;
        wen_d   = req_wen;
        cnt_d   = lat - 4'd1;
        state_d = WAIT;
      end
      WAIT: if (access) begin
        rdata_d = wen_q ? 32'd0 : pmem_read(addr_q);
        state_d = RESP;
      end else cnt_d = cnt_q - 4'd1;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      wen_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
    end
  end
  // The store lands exactly once, in the final WAIT cycle; a reset in that cycle suppresses it.
  always_ff @(posedge clk)
    if (rst_n && access && wen_q) mem[addr_q[AW+1:2]] <= pmem_write(mem[addr_q[AW+1:2]], wdata_q, wmask_q);
  assign unused_addr = ^{addr_q[31:AW+2], addr_q[1:0]};
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_wen   = wen_q;
endmodule

// File: tb/tb_ysyx_25020047_lsu_sram.sv
// tb_ysyx_25020047_lsu_sram: directed checks of latency, data, backpressure and reset for the LSU SRAM slave.
module tb_ysyx_25020047_lsu_sram;
  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_wen;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wmask;
  int          checks = 0, failures = 0;
  logic [31:0] rd;
  logic        wn;
  int          lt, n;
  ysyx_25020047_lsu_sram #(.LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_wen(rsp_wen)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask
  function automatic logic lat_ok(input int l);
`ifdef SRAM_RAND_DELAY_EN
    lat_ok = l >= 2 && l <= 5;
`else
    lat_ok = l == 2;
`endif
  endfunction
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                      output logic [31:0] r, output logic rw, output int l);
    req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m;
    chk("idle_ready", req_ready === 1'b1);
    step();
    req_valid = 1'b0; req_wen = ~w; req_addr = ~a; req_wdata = ~d; req_wmask = ~m;
    l = 0;
    while (!rsp_valid && l < 20) begin
      step();
      l++;
    end
    chk("latency", lat_ok(l) === 1'b1);
    r = rsp_rdata;
    rw = rsp_wen;
    step();
    chk("one_cycle_resp", rsp_valid === 1'b0);
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000000;
    req_wdata = 32'h11111111; req_wmask = 4'hf; rsp_ready = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", req_ready === 1'b1);
    chk("rst_rsp_valid", rsp_valid === 1'b0);
    chk("rst_rsp_rdata", rsp_rdata === 32'h0);
    chk("rst_rsp_wen", rsp_wen === 1'b0);
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", rsp_valid === 1'b0);
    xact(1'b1, 32'h80000000, 32'hDEADBEEF, 4'hf, rd, wn, lt);
    chk("sw_rdata_zero", rd === 32'h0);
    chk("sw_wen", wn === 1'b1);
    xact(1'b0, 32'h80000000, 32'h0, 4'h0, rd, wn, lt);
    chk("lw_deadbeef", rd === 32'hDEADBEEF);
    chk("lw_wen", wn === 1'b0);
    rst_n = 1'b0; req_valid = 1'b1; req_wen = 1'b1; req_wdata = 32'h11111111; req_wmask = 4'hf;
    repeat (3) step();
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    xact(1'b0, 32'h80000000, 32'h0, 4'h0, rd, wn, lt);
    chk("no_write_in_reset", rd === 32'hDEADBEEF);
    xact(1'b1, 32'h80000001, 32'h0000AB00, 4'b0010, rd, wn, lt);
    xact(1'b0, 32'h80000000, 32'h0, 4'h0, rd, wn, lt);
    chk("byte_store", rd === 32'hDEADABEF);
    xact(1'b0, 32'h80000003, 32'h0, 4'h0, rd, wn, lt);
    chk("unaligned_load", rd === 32'hDEADABEF);
    xact(1'b1, 32'h80000000, 32'hFFFFFFFF, 4'h0, rd, wn, lt);
    chk("mask0_wen", wn === 1'b1);
    xact(1'b0, 32'h80000000, 32'h0, 4'h0, rd, wn, lt);
    chk("mask0_nochange", rd === 32'hDEADABEF);
    xact(1'b1, 32'h80000004, 32'h12345678, 4'hf, rd, wn, lt);
    xact(1'b0, 32'h80000004, 32'h0, 4'h0, rd, wn, lt);
    chk("capture_isolated", rd === 32'h12345678);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000000; req_wmask = 4'hf;
    step();
    req_wen = 1'b1; req_addr = 32'h80000004; req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("bp_latency", lat_ok(n) === 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", rsp_valid === 1'b1);
      chk("bp_rdata", rsp_rdata === 32'hDEADABEF);
      chk("bp_req_ready", req_ready === 1'b0);
      chk("bp_wen", rsp_wen === 1'b0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid === 1'b0);
    chk("bp_release_ready", req_ready === 1'b1);
    xact(1'b0, 32'h80000004, 32'h0, 4'h0, rd, wn, lt);
    chk("bp_inputs_ignored", rd === 32'h12345678);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000000; req_wdata = 32'h0; req_wmask = 4'hf;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    chk("midwait_ready", req_ready === 1'b1);
    chk("midwait_valid", rsp_valid === 1'b0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("midwait_no_rsp", rsp_valid === 1'b0);
    xact(1'b0, 32'h80000000, 32'h0, 4'h0, rd, wn, lt);
    chk("midwait_no_write", rd === 32'hDEADABEF);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000008; req_wdata = 32'hCAFEF00D; req_wmask = 4'hf;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("resp_rst_wen", rsp_wen === 1'b1);
    rst_n = 1'b0;
    step();
    chk("resp_rst_valid", rsp_valid === 1'b0);
    chk("resp_rst_wen0", rsp_wen === 1'b0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    xact(1'b0, 32'h80000008, 32'h0, 4'h0, rd, wn, lt);
    chk("resp_rst_write_kept", rd === 32'hCAFEF00D);
    for (int i = 0; i < 8; i++) begin
      xact(1'b1, 32'h80000100 + 32'(i * 4), 32'hA5000000 ^ (32'h01010101 * 32'(i + 1)), 4'hf, rd, wn, lt);
      xact(1'b0, 32'h80000100 + 32'(i * 4), 32'h0, 4'h0, rd, wn, lt);
      chk("b2b_data", rd === (32'hA5000000 ^ (32'h01010101 * 32'(i + 1))));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
